// File: rtl/pcseq_pkg.sv
// Shared types for the PC sequencer: FSM state encoding and halt reason codes.
package pcseq_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StStep   = 2'd2,
      StHalted = 2'd3
   } pcseq_state_e;

   localparam logic [1:0] HR_NONE  = 2'd0;
   localparam logic [1:0] HR_EXT   = 2'd1;
   localparam logic [1:0] HR_LIMIT = 2'd2;
   localparam logic [1:0] HR_LOOP  = 2'd3;

endpackage

// File: rtl/pcseq_trace_buf.sv
// Circular trace buffer of retired PCs. The oldest entry is overwritten once full;
// rd_idx 0 always addresses the oldest valid entry. Depth must be a power of 2.
module pcseq_trace_buf #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [Width-1:0]           wr_data,
   input  logic [$clog2(Depth)-1:0]   rd_idx,
   output logic [Width-1:0]           rd_data,
   output logic [$clog2(Depth):0]     count
);
   localparam int unsigned IdxW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [IdxW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [IdxW:0]    count_q, count_d;
   logic [IdxW-1:0]  base;
   logic [IdxW-1:0]  rd_addr;

   // Next-state: clear on restart, otherwise append and saturate the fill count.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         count_d  = '0;
      end else if (wr_en) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + IdxW'(1);
         if (count_q != (IdxW+1)'(Depth)) begin
            count_d = count_q + (IdxW+1)'(1);
         end
      end
   end

   // Storage needs no reset; only the pointer and count define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Once full, the write pointer points at the oldest entry; before that it is slot 0.
   always_comb begin
      base    = count_q[IdxW] ? wr_ptr_q : '0;
      rd_addr = base + rd_idx;
      rd_data = mem_q[rd_addr];
   end

   assign count = count_q;

endmodule

// File: rtl/cpu_pc_sequencer.sv
// Program-counter driver for CPU_16bit: start/halt/single-step control, retire counter,
// halt detection (external, retire limit, self-loop). Optional trace buffer under the
// PCSEQ_TRACE_EN macro; without it trace_pc and trace_count read as zero.
module cpu_pc_sequencer
   import pcseq_pkg::*;
#(
   parameter int unsigned     PC_W        = 16,
   parameter logic [PC_W-1:0] RESET_VEC   = 16'd9,
   parameter int unsigned     MAX_CYCLES  = 6,
   parameter int unsigned     CNT_W       = 16,
   parameter int unsigned     TRACE_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             halt_req,
   input  logic                             step_mode,
   input  logic                             step_req,
   input  logic [PC_W-1:0]                  pc_next,
   output logic [PC_W-1:0]                  pc_start,
   output logic                             retire,
   output logic                             busy,
   output logic                             done,
   output logic [1:0]                       halt_reason,
   output logic [CNT_W-1:0]                 retire_cnt,
   input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_idx,
   output logic [PC_W-1:0]                  trace_pc,
   output logic [$clog2(TRACE_DEPTH):0]     trace_count
);
   pcseq_state_e     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       reason_q, reason_d;
   logic             retire_int;
   logic             restart;
   logic             limit_hit;

   assign limit_hit = (MAX_CYCLES != 0) && (cnt_q == CNT_W'(MAX_CYCLES - 1));

   // Next-state, retire decision and halt priority: external > limit > self-loop.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      reason_d   = reason_q;
      retire_int = 1'b0;
      restart    = 1'b0;
      case (state_q)
         StIdle, StHalted: begin
            if (start) begin
               restart  = 1'b1;
               state_d  = step_mode ? StStep : StRun;
               pc_d     = RESET_VEC;
               cnt_d    = '0;
               reason_d = HR_NONE;
            end
         end
         StRun: begin
            if (halt_req) begin
               state_d  = StHalted;
               reason_d = HR_EXT;
            end else if (step_mode) begin
               state_d = StStep;
            end else begin
               retire_int = 1'b1;
            end
         end
         StStep: begin
            if (halt_req) begin
               state_d  = StHalted;
               reason_d = HR_EXT;
            end else begin
               retire_int = step_req;
               if (!step_mode) begin
                  state_d = StRun;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (retire_int) begin
         pc_d  = pc_next;
         cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
         if (limit_hit) begin
            state_d  = StHalted;
            reason_d = HR_LIMIT;
         end else if (pc_next == pc_q) begin
            state_d  = StHalted;
            reason_d = HR_LOOP;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         pc_q     <= RESET_VEC;
         cnt_q    <= '0;
         reason_q <= HR_NONE;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         reason_q <= reason_d;
      end
   end

   // Reset asserted mid-run must suppress the commit strobe in that same cycle.
   assign retire      = retire_int & rst_n;
   assign pc_start    = pc_q;
   assign busy        = (state_q == StRun) || (state_q == StStep);
   assign done        = (state_q == StHalted);
   assign halt_reason = reason_q;
   assign retire_cnt  = cnt_q;

`ifdef PCSEQ_TRACE_EN
   pcseq_trace_buf #(
      .Depth (TRACE_DEPTH),
      .Width (PC_W)
   ) u_trace (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (restart),
      .wr_en   (retire),
      .wr_data (pc_q),
      .rd_idx  (trace_idx),
      .rd_data (trace_pc),
      .count   (trace_count)
   );
`else
   logic unused_trace;
   assign unused_trace = ^{trace_idx, restart};
   assign trace_pc     = '0;
   assign trace_count  = '0;
`endif

endmodule

// File: tb/tb_cpu_pc_sequencer.sv
// Scoreboard bench for cpu_pc_sequencer: expected retires are queued by the stimulus
// process and consumed by a monitor on every retire strobe.
module tb_cpu_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst_n, start, halt_req, step_mode, step_req;
   logic [15:0] pc_next, pc_start;
   logic        retire, busy, done;
   logic [1:0]  halt_reason;
   logic [15:0] retire_cnt;
   logic [2:0]  trace_idx;
   logic [15:0] trace_pc;
   logic [3:0]  trace_count;
   logic        stuck;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] cnt;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   // CPU model: next PC is +1, or stuck at 11 for the self-loop case.
   assign pc_next = stuck ? 16'd11 : pc_start + 16'd1;

   cpu_pc_sequencer u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .halt_req    (halt_req),
      .step_mode   (step_mode),
      .step_req    (step_req),
      .pc_next     (pc_next),
      .pc_start    (pc_start),
      .retire      (retire),
      .busy        (busy),
      .done        (done),
      .halt_reason (halt_reason),
      .retire_cnt  (retire_cnt),
      .trace_idx   (trace_idx),
      .trace_pc    (trace_pc),
      .trace_count (trace_count)
   );

`ifdef PCSEQ_TRACE_EN
   logic        start2, busy2, done2, retire2;
   logic [15:0] pc2, cnt2, tpc2;
   logic [1:0]  reason2;
   logic [2:0]  tidx2;
   logic [3:0]  tcnt2;
   logic [15:0] pc_next2;
   assign pc_next2 = pc2 + 16'd1;

   cpu_pc_sequencer #(
      .MAX_CYCLES (10)
   ) u_dut_tr (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start2),
      .halt_req    (1'b0),
      .step_mode   (1'b0),
      .step_req    (1'b0),
      .pc_next     (pc_next2),
      .pc_start    (pc2),
      .retire      (retire2),
      .busy        (busy2),
      .done        (done2),
      .halt_reason (reason2),
      .retire_cnt  (cnt2),
      .trace_idx   (tidx2),
      .trace_pc    (tpc2),
      .trace_count (tcnt2)
   );
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_run(input int first_pc, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc  = 16'(first_pc + i);
         e.cnt = 16'(i);
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check(name, 32'(done), 32'd1);
   endtask

   // Monitor: every retire strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (retire) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_retire: got pc %0d want no retire", pc_start);
         end else begin
            mon_e = exp_q.pop_front();
            check("retire_pc", 32'(pc_start), 32'(mon_e.pc));
            check("retire_cnt", 32'(retire_cnt), 32'(mon_e.cnt));
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; step_mode = 1'b0; step_req = 1'b0;
      trace_idx = '0; stuck = 1'b0;
`ifdef PCSEQ_TRACE_EN
      start2 = 1'b0; tidx2 = '0;
`endif
      tick(); tick();

      // Reset state
      check("rst_pc", 32'(pc_start), 32'd9);
      check("rst_cnt", 32'(retire_cnt), 32'd0);
      check("rst_reason", 32'(halt_reason), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_tcount", 32'(trace_count), 32'd0);
      check("rst_retire", 32'(retire), 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: free run to retire limit
      push_run(9, 6);
      pulse_start();
      check("t1_busy", 32'(busy), 32'd1);
      wait_done("t1_done");
      check("t1_pc", 32'(pc_start), 32'd15);
      check("t1_cnt", 32'(retire_cnt), 32'd6);
      check("t1_reason", 32'(halt_reason), 32'd2);
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_drained", 32'(exp_q.size()), 32'd0);
`ifndef PCSEQ_TRACE_EN
      trace_idx = 3'd2;
      #1;
      check("t1_tcount_off", 32'(trace_count), 32'd0);
      check("t1_tpc_off", 32'(trace_pc), 32'd0);
`endif

      // 2: restart from HALTED, external halt after three retires
      push_run(9, 3);
      pulse_start();
      check("t2_reason_clr", 32'(halt_reason), 32'd0);
      tick(); tick(); tick();
      halt_req = 1'b1;
      #1;
      check("t2_retire_gated", 32'(retire), 32'd0);
      tick();
      check("t2_done", 32'(done), 32'd1);
      check("t2_reason", 32'(halt_reason), 32'd1);
      check("t2_pc", 32'(pc_start), 32'd12);
      check("t2_cnt", 32'(retire_cnt), 32'd3);
      halt_req = 1'b0;
      check("t2_drained", 32'(exp_q.size()), 32'd0);

      // 3: self-loop detection
      stuck = 1'b1;
      exp_q.push_back('{pc: 16'd9, cnt: 16'd0});
      exp_q.push_back('{pc: 16'd11, cnt: 16'd1});
      pulse_start();
      wait_done("t3_done");
      check("t3_reason", 32'(halt_reason), 32'd3);
      check("t3_cnt", 32'(retire_cnt), 32'd2);
      check("t3_pc", 32'(pc_start), 32'd11);
      check("t3_drained", 32'(exp_q.size()), 32'd0);
      stuck = 1'b0;

      // 4: single-step, two pulses four cycles apart
      step_mode = 1'b1;
      push_run(9, 2);
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         check("t4_idle_retire", 32'(retire), 32'd0);
         tick();
      end
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      tick(); tick(); tick();
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      tick(); tick();
      check("t4_pc", 32'(pc_start), 32'd11);
      check("t4_cnt", 32'(retire_cnt), 32'd2);
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_drained", 32'(exp_q.size()), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      step_mode = 1'b0;

      // 5: reset mid-run at PC 13, with an ignored start while running
      push_run(9, 4);
      pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      check("t5_pre_pc", 32'(pc_start), 32'd13);
      rst_n = 1'b0;
      #1;
      check("t5_retire_rst", 32'(retire), 32'd0);
      tick();
      check("t5_pc", 32'(pc_start), 32'd9);
      check("t5_cnt", 32'(retire_cnt), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_reason", 32'(halt_reason), 32'd0);
      rst_n = 1'b1;
      tick();
      check("t5_drained", 32'(exp_q.size()), 32'd0);

      // start together with halt_req in IDLE: run for one cycle then halt
      start = 1'b1;
      halt_req = 1'b1;
      tick();
      start = 1'b0;
      check("t7_busy", 32'(busy), 32'd1);
      check("t7_retire", 32'(retire), 32'd0);
      tick();
      check("t7_done", 32'(done), 32'd1);
      check("t7_reason", 32'(halt_reason), 32'd1);
      check("t7_cnt", 32'(retire_cnt), 32'd0);
      halt_req = 1'b0;

`ifdef PCSEQ_TRACE_EN
      // 6: trace wrap with a 10-retire limit
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int n = 0; n < 40 && !done2; n++) tick();
      check("t6_done", 32'(done2), 32'd1);
      check("t6_tcount", 32'(tcnt2), 32'd8);
      tidx2 = 3'd0;
      #1;
      check("t6_idx0", 32'(tpc2), 32'd11);
      tidx2 = 3'd3;
      #1;
      check("t6_idx3", 32'(tpc2), 32'd14);
      tidx2 = 3'd7;
      #1;
      check("t6_idx7", 32'(tpc2), 32'd18);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
